arith_issue_queue: RTL and testbench
====================================

// Module: arith_issue_queue
// PURPOSE
//  Reservation station directly upstream of the arith execute unit.
//  - Buffers dispatched integer-ALU instructions until both source operands are available.
//  - Captures operand values broadcast on the common data bus (CDB).
//  - Issues the oldest ready entry, one per cycle, as a registered request:
//    arith_request/pc/inst/rs1_value/rs2_value.
// PARAMETERS
//  DEPTH  4  number of entries, >=2
//  TAG_W  6  width of physical-register/ROB tags
// PORTS
//  clk_i                 in   1      clock
//  reset_i               in   1      synchronous active-high reset
//  flush_i               in   1      mispredict flush, drops all entries
//  dispatch_valid_i      in   1      dispatch offers an instruction
//  dispatch_ready_o      out  1      queue can accept this cycle
//  dispatch_pc_i         in   32     instruction PC
//  dispatch_inst_i       in   32     raw instruction word
//  dispatch_rd_tag_i     in   TAG_W  destination tag
//  dispatch_rsN_ready_i  in   1      N=1,2: operand value already valid
//  dispatch_rsN_tag_i    in   TAG_W  N=1,2: producer tag when not ready
//  dispatch_rsN_value_i  in   32     N=1,2: operand value when ready
//  cdb_valid_i           in   1      CDB broadcast valid
//  cdb_tag_i             in   TAG_W  broadcast tag
//  cdb_value_i           in   32     broadcast value
//  arith_request_o       out  1      issue valid to arith unit, no backpressure
//  pc_o, inst_o          out  32     issued pc / instruction
//  rs1_value_o           out  32     issued rs1 operand
//  rs2_value_o           out  32     issued rs2 operand
//  rd_tag_o              out  TAG_W  issued destination tag
//  count_o               out  $clog2(DEPTH+1)  occupied entries
// BEHAVIOUR
//  - Reset or flush: all entries invalid, count_o=0; all outputs 0 next cycle.
//  - Dispatch and CDB inputs are ignored in the cycle flush_i or reset_i is high.
//  - Storage is an age-ordered collapsing array, entry 0 oldest.
//    - Dispatch appends at index count_o.
//    - Issue removes the selected entry and shifts the younger entries down.
//  - dispatch_ready_o = (count_o < DEPTH). Registered occupancy only; no same-cycle issue credit.
//  - Dispatch when dispatch_valid_i & dispatch_ready_o:
//    - rsN marked ready if dispatch_rsN_ready_i, or if cdb_valid_i and cdb_tag_i==dispatch_rsN_tag_i.
//    - In the CDB-match case the value is cdb_value_i; no wakeup is ever missed.
//  - Wakeup: each valid entry with a pending operand whose tag == cdb_tag_i while cdb_valid_i
//    captures cdb_value_i and sets ready at the clock edge. Both operands may wake the same cycle.
//  - Select: the lowest-index entry with both ready bits set, using registered state.
//    - The selection is registered into the outputs with arith_request_o=1 at the next edge.
//    - The entry leaves the queue at that same edge.
//  - Latency: dispatch with both operands ready accepted at edge E0 -> arith_request_o=1 after E1.
//  - No ready entry: arith_request_o=0; data outputs hold their last values.
//  - Simultaneous dispatch and issue: count_o unchanged. The new entry lands at index count_o-1
//    after the collapse and is never overwritten.
//  - Full plus issue in the same cycle: dispatch still stalled (ready was 0); count_o -> DEPTH-1.
//  - count_o never exceeds DEPTH; no underflow when empty.
// CONFIGURATION
//  WAKEUP_BYPASS_EN
//    defined:
//      - An entry whose last pending operand(s) match the current CDB broadcast is selectable in
//        that cycle; the CDB value is forwarded into the rsN_value_o register.
//      - CDB-to-issue latency is 1 edge.
//      - Age priority still applies among all selectable entries.
//    undefined:
//      - Woken entries become selectable the cycle after capture; CDB-to-issue latency is 2 edges.
// TESTING
//  1 Reset 2 cycles -> arith_request_o=0, count_o=0, dispatch_ready_o=1, all data outputs 0.
//  2 Dispatch inst=0x00518093 pc=0x4, rs1 ready=0x2, rs2 ready=0x0
//    -> one edge later count_o=1; next edge arith_request_o=1, inst_o=0x00518093,
//       rs1_value_o=0x2, count_o=0.
//  3 Dispatch sub 0x40208133, rs1 ready=0x10, rs2 tag=5 pending; then CDB tag=5 value=0x5
//    -> issue with rs2_value_o=0x5. Without bypass: 2 edges after the CDB cycle.
//       With WAKEUP_BYPASS_EN: 1 edge after the CDB cycle.
//  4 Fill DEPTH=4 with pending entries (tags 1..4)
//    -> dispatch_ready_o=0 and a 5th dispatch is not accepted.
//    Then wake tag 3 -> entry 2 issues first; after the issue edge dispatch_ready_o=1, count_o=3.
//  5 Two entries become ready in the same cycle -> older (lower index) issues first,
//    younger the next cycle; arith_request_o is high for 2 consecutive cycles.
//  6 flush_i with 3 entries and dispatch_valid_i=1 in the same cycle
//    -> next cycle count_o=0, arith_request_o=0, flushed dispatch not stored.
//    Later CDB broadcasts of the flushed tags cause no issue.

Source files
------------

// File: rtl/arith_issue_queue.sv
// arith_issue_queue: age-ordered collapsing reservation station feeding the arith execute unit.
// Build option: define WAKEUP_BYPASS_EN to make a CDB-woken entry selectable in the broadcast cycle.
module arith_issue_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       flush_i,
  input  logic                       dispatch_valid_i,
  output logic                       dispatch_ready_o,
  input  logic [31:0]                dispatch_pc_i,
  input  logic [31:0]                dispatch_inst_i,
  input  logic [TAG_W-1:0]           dispatch_rd_tag_i,
  input  logic                       dispatch_rs1_ready_i,
  input  logic [TAG_W-1:0]           dispatch_rs1_tag_i,
  input  logic [31:0]                dispatch_rs1_value_i,
  input  logic                       dispatch_rs2_ready_i,
  input  logic [TAG_W-1:0]           dispatch_rs2_tag_i,
  input  logic [31:0]                dispatch_rs2_value_i,
  input  logic                       cdb_valid_i,
  input  logic [TAG_W-1:0]           cdb_tag_i,
  input  logic [31:0]                cdb_value_i,
  output logic                       arith_request_o,
  output logic [31:0]                pc_o,
  output logic [31:0]                inst_o,
  output logic [31:0]                rs1_value_o,
  output logic [31:0]                rs2_value_o,
  output logic [TAG_W-1:0]           rd_tag_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0]      pc;
    logic [31:0]      inst;
    logic [TAG_W-1:0] rd_tag;
    logic             rs1_rdy;
    logic [TAG_W-1:0] rs1_tag;
    logic [31:0]      rs1_val;
    logic             rs2_rdy;
    logic [TAG_W-1:0] rs2_tag;
    logic [31:0]      rs2_val;
  } entry_t;

  entry_t           ent_q [DEPTH];
  entry_t           woke  [DEPTH];
  entry_t           ent_d [DEPTH];
  entry_t           disp_ent;
  entry_t           sel_ent;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] disp_slot;
  logic [DEPTH-1:0] occupied;
  logic [DEPTH-1:0] cand;
  logic             sel_vld;
  logic [IDX_W-1:0] sel_idx;
  logic             disp_fire;

  assign count_o          = count_q;
  assign dispatch_ready_o = (count_q < CNT_W'(DEPTH));
  assign disp_fire        = dispatch_valid_i && dispatch_ready_o;

  // Capture the CDB into every occupied entry still waiting on the broadcast tag.
  always_comb begin
    occupied = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupied[i] = (CNT_W'(i) < count_q);
      woke[i]     = ent_q[i];
      if (cdb_valid_i && !ent_q[i].rs1_rdy && (ent_q[i].rs1_tag == cdb_tag_i)) begin
        woke[i].rs1_rdy = 1'b1;
        woke[i].rs1_val = cdb_value_i;
      end
      if (cdb_valid_i && !ent_q[i].rs2_rdy && (ent_q[i].rs2_tag == cdb_tag_i)) begin
        woke[i].rs2_rdy = 1'b1;
        woke[i].rs2_val = cdb_value_i;
      end
    end
  end

  // Oldest ready entry wins; the bypass build also counts operands arriving on the CDB now.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write so no latch is inferred.
    cand    = '0;
    sel_vld = 1'b0;
    sel_idx = '0;
    sel_ent = '0;
    for (int i = 0; i < DEPTH; i++) begin
`ifdef WAKEUP_BYPASS_EN
      cand[i] = occupied[i] && woke[i].rs1_rdy && woke[i].rs2_rdy;
`else
      cand[i] = occupied[i] && ent_q[i].rs1_rdy && ent_q[i].rs2_rdy;
`endif
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (cand[i]) begin
        sel_vld = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (sel_vld && (IDX_W'(i) == sel_idx)) sel_ent = woke[i];
    end
  end

  // A dispatch matching the live broadcast is born ready so the wakeup is never lost.
  always_comb begin
    disp_ent         = '0;
    disp_ent.pc      = dispatch_pc_i;
    disp_ent.inst    = dispatch_inst_i;
    disp_ent.rd_tag  = dispatch_rd_tag_i;
    disp_ent.rs1_tag = dispatch_rs1_tag_i;
    disp_ent.rs2_tag = dispatch_rs2_tag_i;
    disp_ent.rs1_rdy = dispatch_rs1_ready_i || (cdb_valid_i && (cdb_tag_i == dispatch_rs1_tag_i));
    disp_ent.rs2_rdy = dispatch_rs2_ready_i || (cdb_valid_i && (cdb_tag_i == dispatch_rs2_tag_i));
    disp_ent.rs1_val = dispatch_rs1_ready_i ? dispatch_rs1_value_i : cdb_value_i;
    disp_ent.rs2_val = dispatch_rs2_ready_i ? dispatch_rs2_value_i : cdb_value_i;
  end

  // Collapse over the issued slot, then append the new entry behind the survivors.
  always_comb begin
    disp_slot = count_q - CNT_W'(sel_vld);
    count_d   = count_q + CNT_W'(disp_fire) - CNT_W'(sel_vld);
    for (int i = 0; i < DEPTH; i++) ent_d[i] = woke[i];
    if (sel_vld) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (IDX_W'(i) >= sel_idx) ent_d[i] = woke[i + 1];
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (disp_fire && (CNT_W'(i) == disp_slot)) ent_d[i] = disp_ent;
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset_i || flush_i) begin
      count_q         <= '0;
      arith_request_o <= 1'b0;
      pc_o            <= '0;
      inst_o          <= '0;
      rs1_value_o     <= '0;
      rs2_value_o     <= '0;
      rd_tag_o        <= '0;
    end else begin
      count_q         <= count_d;
      arith_request_o <= sel_vld;
      if (sel_vld) begin
        pc_o        <= sel_ent.pc;
        inst_o      <= sel_ent.inst;
        rs1_value_o <= sel_ent.rs1_val;
        rs2_value_o <= sel_ent.rs2_val;
        rd_tag_o    <= sel_ent.rd_tag;
      end
    end
  end

  // NOTE: entry payloads are not reset; occupancy alone decides which slots hold live data.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
  end

endmodule

// File: tb/tb_arith_issue_queue.sv
// Randomized and directed bench for arith_issue_queue against a queue-based reference model.
module tb_arith_issue_queue;

  localparam int DEPTH = 4;
  localparam int TAG_W = 6;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk_i = 1'b0;
  logic             reset_i, flush_i, dispatch_valid_i, dispatch_ready_o;
  logic [31:0]      dispatch_pc_i, dispatch_inst_i;
  logic [TAG_W-1:0] dispatch_rd_tag_i;
  logic             dispatch_rs1_ready_i, dispatch_rs2_ready_i;
  logic [TAG_W-1:0] dispatch_rs1_tag_i, dispatch_rs2_tag_i;
  logic [31:0]      dispatch_rs1_value_i, dispatch_rs2_value_i;
  logic             cdb_valid_i;
  logic [TAG_W-1:0] cdb_tag_i;
  logic [31:0]      cdb_value_i;
  logic             arith_request_o;
  logic [31:0]      pc_o, inst_o, rs1_value_o, rs2_value_o;
  logic [TAG_W-1:0] rd_tag_o;
  logic [CNT_W-1:0] count_o;

  always #5 clk_i = ~clk_i;

  arith_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i),
    .dispatch_valid_i(dispatch_valid_i), .dispatch_ready_o(dispatch_ready_o),
    .dispatch_pc_i(dispatch_pc_i), .dispatch_inst_i(dispatch_inst_i),
    .dispatch_rd_tag_i(dispatch_rd_tag_i),
    .dispatch_rs1_ready_i(dispatch_rs1_ready_i), .dispatch_rs1_tag_i(dispatch_rs1_tag_i),
    .dispatch_rs1_value_i(dispatch_rs1_value_i),
    .dispatch_rs2_ready_i(dispatch_rs2_ready_i), .dispatch_rs2_tag_i(dispatch_rs2_tag_i),
    .dispatch_rs2_value_i(dispatch_rs2_value_i),
    .cdb_valid_i(cdb_valid_i), .cdb_tag_i(cdb_tag_i), .cdb_value_i(cdb_value_i),
    .arith_request_o(arith_request_o), .pc_o(pc_o), .inst_o(inst_o),
    .rs1_value_o(rs1_value_o), .rs2_value_o(rs2_value_o),
    .rd_tag_o(rd_tag_o), .count_o(count_o)
  );

  typedef struct {
    logic [31:0]      pc;
    logic [31:0]      inst;
    logic [TAG_W-1:0] rd;
    logic             r1;
    logic [TAG_W-1:0] t1;
    logic [31:0]      v1;
    logic             r2;
    logic [TAG_W-1:0] t2;
    logic [31:0]      v2;
  } ent_t;

  ent_t             q[$];
  logic             exp_req;
  logic [31:0]      exp_pc, exp_inst, exp_v1, exp_v2;
  logic [TAG_W-1:0] exp_rd;
  int               n_checks = 0;
  int               n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: a list in age order; oldest fully-ready entry leaves, arrivals join the tail.
  task automatic model_update();
    int   sel;
    logic ok1, ok2, accept;
    ent_t e;
    if (reset_i || flush_i) begin
      q.delete();
      exp_req = 1'b0;
      exp_pc = '0; exp_inst = '0; exp_v1 = '0; exp_v2 = '0; exp_rd = '0;
      return;
    end
    accept = dispatch_valid_i && (q.size() < DEPTH);
    sel = -1;
    foreach (q[i]) begin
      ok1 = q[i].r1;
      ok2 = q[i].r2;
`ifdef WAKEUP_BYPASS_EN
      ok1 = ok1 || (cdb_valid_i && q[i].t1 == cdb_tag_i);
      ok2 = ok2 || (cdb_valid_i && q[i].t2 == cdb_tag_i);
`endif
      if (sel < 0 && ok1 && ok2) sel = i;
    end
    foreach (q[i]) begin
      if (cdb_valid_i && !q[i].r1 && q[i].t1 == cdb_tag_i) begin q[i].r1 = 1'b1; q[i].v1 = cdb_value_i; end
      if (cdb_valid_i && !q[i].r2 && q[i].t2 == cdb_tag_i) begin q[i].r2 = 1'b1; q[i].v2 = cdb_value_i; end
    end
    exp_req = (sel >= 0);
    if (sel >= 0) begin
      exp_pc = q[sel].pc; exp_inst = q[sel].inst; exp_rd = q[sel].rd;
      exp_v1 = q[sel].v1; exp_v2 = q[sel].v2;
      q.delete(sel);
    end
    if (accept) begin
      e.pc = dispatch_pc_i; e.inst = dispatch_inst_i; e.rd = dispatch_rd_tag_i;
      e.t1 = dispatch_rs1_tag_i; e.t2 = dispatch_rs2_tag_i;
      e.r1 = dispatch_rs1_ready_i; e.v1 = dispatch_rs1_value_i;
      e.r2 = dispatch_rs2_ready_i; e.v2 = dispatch_rs2_value_i;
      if (!e.r1 && cdb_valid_i && e.t1 == cdb_tag_i) begin e.r1 = 1'b1; e.v1 = cdb_value_i; end
      if (!e.r2 && cdb_valid_i && e.t2 == cdb_tag_i) begin e.r2 = 1'b1; e.v2 = cdb_value_i; end
      q.push_back(e);
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".req"},   32'(arith_request_o),  32'(exp_req));
    check({tag, ".count"}, 32'(count_o),          32'(q.size()));
    check({tag, ".ready"}, 32'(dispatch_ready_o), 32'(q.size() < DEPTH));
    check({tag, ".pc"},    pc_o,                  exp_pc);
    check({tag, ".inst"},  inst_o,                exp_inst);
    check({tag, ".rs1"},   rs1_value_o,           exp_v1);
    check({tag, ".rs2"},   rs2_value_o,           exp_v2);
    check({tag, ".rd"},    32'(rd_tag_o),         32'(exp_rd));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk_i);
    model_update();
    @(negedge clk_i);
    compare_all(tag);
  endtask

  task automatic idle();
    reset_i = 1'b0; flush_i = 1'b0; dispatch_valid_i = 1'b0;
    dispatch_pc_i = '0; dispatch_inst_i = '0; dispatch_rd_tag_i = '0;
    dispatch_rs1_ready_i = 1'b0; dispatch_rs1_tag_i = '0; dispatch_rs1_value_i = '0;
    dispatch_rs2_ready_i = 1'b0; dispatch_rs2_tag_i = '0; dispatch_rs2_value_i = '0;
    cdb_valid_i = 1'b0; cdb_tag_i = '0; cdb_value_i = '0;
  endtask

  task automatic set_disp(input logic [31:0] pc, input logic [31:0] inst, input logic [TAG_W-1:0] rd,
                          input logic r1, input logic [TAG_W-1:0] t1, input logic [31:0] v1,
                          input logic r2, input logic [TAG_W-1:0] t2, input logic [31:0] v2);
    dispatch_valid_i = 1'b1; dispatch_pc_i = pc; dispatch_inst_i = inst; dispatch_rd_tag_i = rd;
    dispatch_rs1_ready_i = r1; dispatch_rs1_tag_i = t1; dispatch_rs1_value_i = v1;
    dispatch_rs2_ready_i = r2; dispatch_rs2_tag_i = t2; dispatch_rs2_value_i = v2;
  endtask

  task automatic set_cdb(input logic [TAG_W-1:0] tag, input logic [31:0] val);
    cdb_valid_i = 1'b1; cdb_tag_i = tag; cdb_value_i = val;
  endtask

  initial begin
    idle();
    // Reset state
    reset_i = 1'b1;
    cycle("rst0");
    cycle("rst1");
    check("rst.req", 32'(arith_request_o), 32'd0);
    check("rst.count", 32'(count_o), 32'd0);
    check("rst.ready", 32'(dispatch_ready_o), 32'd1);
    idle();

    // Both operands ready: issue one edge after acceptance
    set_disp(32'h4, 32'h0051_8093, 6'd1, 1'b1, 6'd0, 32'h2, 1'b1, 6'd0, 32'h0);
    cycle("add.acc");
    check("add.count1", 32'(count_o), 32'd1);
    idle();
    cycle("add.iss");
    check("add.req", 32'(arith_request_o), 32'd1);
    check("add.inst", inst_o, 32'h0051_8093);
    check("add.rs1", rs1_value_o, 32'h2);
    check("add.count0", 32'(count_o), 32'd0);

    // Pending rs2 woken by the CDB
    set_disp(32'h8, 32'h4020_8133, 6'd2, 1'b1, 6'd0, 32'h10, 1'b0, 6'd5, 32'h0);
    cycle("sub.acc");
    idle();
    cycle("sub.wait");
    check("sub.noreq", 32'(arith_request_o), 32'd0);
    set_cdb(6'd5, 32'h5);
    cycle("sub.cdb");
    idle();
`ifndef WAKEUP_BYPASS_EN
    check("sub.lat2", 32'(arith_request_o), 32'd0);
    cycle("sub.cap");
`endif
    check("sub.req", 32'(arith_request_o), 32'd1);
    check("sub.rs2", rs2_value_o, 32'h5);
    cycle("sub.after");

    // Fill with pending entries, reject a fifth, wake the third
    for (int i = 1; i <= 4; i++) begin
      set_disp(32'h100 + 32'(i * 4), 32'h13, TAG_W'(16 + i), 1'b0, TAG_W'(i), 32'h0, 1'b1, 6'd0, 32'hA0 + 32'(i));
      cycle("fill");
    end
    check("full.ready", 32'(dispatch_ready_o), 32'd0);
    set_disp(32'h200, 32'h13, 6'd30, 1'b1, 6'd0, 32'h1, 1'b1, 6'd0, 32'h1);
    cycle("full.reject");
    check("full.count", 32'(count_o), 32'd4);
    idle();
    set_cdb(6'd3, 32'h33);
    cycle("full.cdb");
    idle();
`ifndef WAKEUP_BYPASS_EN
    cycle("full.cap");
`endif
    check("full.req", 32'(arith_request_o), 32'd1);
    check("full.rd", 32'(rd_tag_o), 32'd19);
    check("full.count3", 32'(count_o), 32'd3);
    check("full.ready1", 32'(dispatch_ready_o), 32'd1);

    // Flush with a simultaneous dispatch; flushed tags must not wake anything
    set_disp(32'h300, 32'h13, 6'd31, 1'b1, 6'd0, 32'h7, 1'b1, 6'd0, 32'h7);
    flush_i = 1'b1;
    cycle("flush");
    check("flush.count", 32'(count_o), 32'd0);
    check("flush.req", 32'(arith_request_o), 32'd0);
    idle();
    for (int t = 1; t <= 4; t++) begin
      set_cdb(TAG_W'(t), 32'hDEAD_0000 + 32'(t));
      cycle("flush.cdb");
      check("flush.noreq", 32'(arith_request_o), 32'd0);
    end
    idle();
    cycle("flush.idle");

    // Two entries woken together: older first, then younger
    set_disp(32'h400, 32'h13, 6'd40, 1'b0, 6'd9, 32'h0, 1'b1, 6'd0, 32'h1);
    cycle("pair.a");
    set_disp(32'h404, 32'h13, 6'd41, 1'b0, 6'd9, 32'h0, 1'b1, 6'd0, 32'h2);
    cycle("pair.b");
    idle();
    set_cdb(6'd9, 32'h99);
    cycle("pair.cdb");
    idle();
`ifndef WAKEUP_BYPASS_EN
    check("pair.lat2", 32'(arith_request_o), 32'd0);
    cycle("pair.cap");
`endif
    check("pair.req0", 32'(arith_request_o), 32'd1);
    check("pair.pc0", pc_o, 32'h400);
    cycle("pair.second");
    check("pair.req1", 32'(arith_request_o), 32'd1);
    check("pair.pc1", pc_o, 32'h404);
    check("pair.rs1", rs1_value_o, 32'h99);
    cycle("pair.done");
    check("pair.req2", 32'(arith_request_o), 32'd0);

    // Randomized traffic with a small tag space so matches are frequent
    for (int n = 0; n < 3000; n++) begin
      idle();
      reset_i = ($urandom_range(0, 299) == 0);
      flush_i = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 9) < 6)
        set_disp($urandom, $urandom, TAG_W'($urandom_range(0, 63)),
                 1'($urandom_range(0, 1)), TAG_W'($urandom_range(1, 7)), $urandom,
                 1'($urandom_range(0, 1)), TAG_W'($urandom_range(1, 7)), $urandom);
      if ($urandom_range(0, 1) == 1)
        set_cdb(TAG_W'($urandom_range(1, 7)), $urandom);
      cycle("rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
